// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequenced ALU wrapper: op codes, flag indices, FSM states.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FLAG_N = 4;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_A = 1;
    localparam int unsigned FLAG_E = 2;
    localparam int unsigned FLAG_Z = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SHR = 3'd1,
        OP_SHL = 3'd2,
        OP_NOT = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_NOP = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Only the arithmetic/shift ops produce a meaningful carry-out.
    function automatic logic op_keeps_carry(input logic [OP_W-1:0] op);
        return (op <= OP_W'(OP_SHL));
    endfunction

endpackage

// File: rtl/alu_seq_flags.sv
// Four-bit status flag register (C, A, E, Z) with capture enable and carry clear.
module alu_seq_flags
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic              c_clr,
    input  logic [FLAG_N-1:0] flag_in,
    output logic [FLAG_N-1:0] flags
);

    logic [FLAG_N-1:0] flags_q;
    logic [FLAG_N-1:0] flags_d;

    // Next flag value: load all four on capture, optionally forcing carry low.
    always_comb begin
        flags_d = flags_q;
        if (cap_en) begin
            flags_d = flag_in;
            if (c_clr) begin
                flags_d[FLAG_C] = 1'b0;
            end
        end
    end

    // Flag storage, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/alu_seq.sv
// Sequencer that presents latched operands to an external ALU for SETTLE cycles,
// captures its result and flags, and holds them until the consumer is ready.
// Optional feature macro: ALU_SEQ_CARRY_CHAIN_EN (carry-in = wuse_c & stored C).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              wreq,
    output logic              wack,
    input  logic [OP_W-1:0]   bop,
    input  logic [DATA_W-1:0] ba,
    input  logic [DATA_W-1:0] bb,
    input  logic              wuse_c,
    output logic [DATA_W-1:0] bas,
    output logic [DATA_W-1:0] bbs,
    output logic              wci,
    output logic [OP_W-1:0]   bops,
    input  logic [DATA_W-1:0] bcs,
    input  logic              wco,
    input  logic              weqo,
    input  logic              walo,
    input  logic              wz,
    output logic [DATA_W-1:0] bres,
    output logic              wflag_c,
    output logic              wflag_a,
    output logic              wflag_e,
    output logic              wflag_z,
    output logic              wvalid,
    input  logic              wrdy
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                cin_q, cin_d;
    logic [DATA_W-1:0]   bres_q, bres_d;
    logic                wack_q, wack_d;
    logic                wvalid_q, wvalid_d;
    logic [DATA_W-1:0]   bas_q, bas_d, bbs_q, bbs_d;
    logic [OP_W-1:0]     bops_q, bops_d;
    logic                wci_q, wci_d;

    logic                cin_next;
    logic                cap_en;
    logic [FLAG_N-1:0]   flag_in;
    logic [FLAG_N-1:0]   flags;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
    assign cin_next = wuse_c & flags[FLAG_C];
`else
    logic unused_wuse_c;
    assign unused_wuse_c = wuse_c;
    assign cin_next      = 1'b0;
`endif

    // Capture happens on the last settle edge; NOP leaves result and flags alone.
    assign cap_en = (state_q == ST_SETTLE) && (cnt_q == '0) && (op_q != OP_NOP);

    always_comb begin
        flag_in         = '0;
        flag_in[FLAG_C] = wco;
        flag_in[FLAG_A] = walo;
        flag_in[FLAG_E] = weqo;
        flag_in[FLAG_Z] = wz;
    end

    // Next-state, operand latch, settle counter and registered output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cin_d    = cin_q;
        bres_d   = bres_q;
        case (state_q)
            ST_IDLE: begin
                if (wreq) begin
                    a_d     = ba;
                    b_d     = bb;
                    op_d    = bop;
                    cin_d   = cin_next;
                    cnt_d   = CNT_W'(SETTLE - 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    if (op_q != OP_NOP) begin
                        bres_d = bcs;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (wrdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wack_d   = (state_d == ST_IDLE);
        wvalid_d = (state_d == ST_HOLD);
        if (state_d == ST_SETTLE) begin
            bas_d  = a_d;
            bbs_d  = b_d;
            bops_d = op_d;
            wci_d  = cin_d;
        end else begin
            bas_d  = '0;
            bbs_d  = '0;
            bops_d = OP_NOP;
            wci_d  = 1'b0;
        end
    end

    // State and output registers; reset aborts any op in flight.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cin_q    <= 1'b0;
            bres_q   <= '0;
            wack_q   <= 1'b1;
            wvalid_q <= 1'b0;
            bas_q    <= '0;
            bbs_q    <= '0;
            bops_q   <= OP_NOP;
            wci_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cin_q    <= cin_d;
            bres_q   <= bres_d;
            wack_q   <= wack_d;
            wvalid_q <= wvalid_d;
            bas_q    <= bas_d;
            bbs_q    <= bbs_d;
            bops_q   <= bops_d;
            wci_q    <= wci_d;
        end
    end

    alu_seq_flags u_flags (
        .clk     (wclk),
        .rst     (wrst),
        .cap_en  (cap_en),
        .c_clr   (!op_keeps_carry(op_q)),
        .flag_in (flag_in),
        .flags   (flags)
    );

    assign wack    = wack_q;
    assign wvalid  = wvalid_q;
    assign bres    = bres_q;
    assign bas     = bas_q;
    assign bbs     = bbs_q;
    assign bops    = bops_q;
    assign wci     = wci_q;
    assign wflag_c = flags[FLAG_C];
    assign wflag_a = flags[FLAG_A];
    assign wflag_e = flags[FLAG_E];
    assign wflag_z = flags[FLAG_Z];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: two instances (SETTLE=1 and SETTLE=4), each paired with a
// behavioural ALU on its ALU-facing ports, checked against a transaction-level model.
module tb_alu_seq;

    typedef struct packed {
        logic       co;
        logic       al;
        logic       eq;
        logic       z;
        logic [7:0] res;
    } alu_t;

    logic       clk;
    logic       wrst_v   [2];
    logic       wreq_v   [2];
    logic       wack_v   [2];
    logic [2:0] bop_v    [2];
    logic [7:0] ba_v     [2];
    logic [7:0] bb_v     [2];
    logic       wuse_v   [2];
    logic [7:0] bas_v    [2];
    logic [7:0] bbs_v    [2];
    logic       wci_v    [2];
    logic [2:0] bops_v   [2];
    alu_t       alu_o    [2];
    logic [7:0] bres_v   [2];
    logic       fc_v     [2];
    logic       fa_v     [2];
    logic       fe_v     [2];
    logic       fz_v     [2];
    logic       wvalid_v [2];
    logic       wrdy_v   [2];

    logic [7:0] exp_res   [2];
    logic [3:0] exp_flags [2];

    int n_checks;
    int n_errors;

    function automatic alu_t alu_f(input logic [2:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic ci);
        alu_t r;
        logic [8:0] sum;
        r = '0;
        case (op)
            3'd0: begin
                sum   = {1'b0, a} + {1'b0, b} + 9'(ci);
                r.res = sum[7:0];
                r.co  = sum[8];
            end
            3'd1: begin r.res = a >> 1; r.co = a[0]; end
            3'd2: begin r.res = a << 1; r.co = a[7]; end
            3'd3: r.res = ~a;
            3'd4: r.res = a & b;
            3'd5: r.res = a | b;
            3'd6: r.res = a ^ b;
            default: r.res = 8'h00;
        endcase
        r.eq = (a == b);
        r.al = (a < b);
        r.z  = (r.res == 8'h00);
        return r;
    endfunction

    assign alu_o[0] = alu_f(bops_v[0], bas_v[0], bbs_v[0], wci_v[0]);
    assign alu_o[1] = alu_f(bops_v[1], bas_v[1], bbs_v[1], wci_v[1]);

    alu_seq #(.SETTLE(1)) u_dut_s1 (
        .wclk(clk), .wrst(wrst_v[0]), .wreq(wreq_v[0]), .wack(wack_v[0]),
        .bop(bop_v[0]), .ba(ba_v[0]), .bb(bb_v[0]), .wuse_c(wuse_v[0]),
        .bas(bas_v[0]), .bbs(bbs_v[0]), .wci(wci_v[0]), .bops(bops_v[0]),
        .bcs(alu_o[0].res), .wco(alu_o[0].co), .weqo(alu_o[0].eq),
        .walo(alu_o[0].al), .wz(alu_o[0].z),
        .bres(bres_v[0]), .wflag_c(fc_v[0]), .wflag_a(fa_v[0]),
        .wflag_e(fe_v[0]), .wflag_z(fz_v[0]), .wvalid(wvalid_v[0]), .wrdy(wrdy_v[0])
    );

    alu_seq #(.SETTLE(4)) u_dut_s4 (
        .wclk(clk), .wrst(wrst_v[1]), .wreq(wreq_v[1]), .wack(wack_v[1]),
        .bop(bop_v[1]), .ba(ba_v[1]), .bb(bb_v[1]), .wuse_c(wuse_v[1]),
        .bas(bas_v[1]), .bbs(bbs_v[1]), .wci(wci_v[1]), .bops(bops_v[1]),
        .bcs(alu_o[1].res), .wco(alu_o[1].co), .weqo(alu_o[1].eq),
        .walo(alu_o[1].al), .wz(alu_o[1].z),
        .bres(bres_v[1]), .wflag_c(fc_v[1]), .wflag_a(fa_v[1]),
        .wflag_e(fe_v[1]), .wflag_z(fz_v[1]), .wvalid(wvalid_v[1]), .wrdy(wrdy_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] flags_of(input int i);
        return {fc_v[i], fa_v[i], fe_v[i], fz_v[i]};
    endfunction

    // Idle-side view of one instance: no ALU enable, nothing valid.
    task automatic chk_idle_drive(input int i, input string tag);
        chk({tag, "_bops"}, 32'(bops_v[i]), 32'd7);
        chk({tag, "_bas"},  32'(bas_v[i]),  32'd0);
        chk({tag, "_wci"},  32'(wci_v[i]),  32'd0);
    endtask

    // One complete transaction with optional consumer back-pressure in HOLD.
    task automatic do_op(input int i, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic usec, input int hold);
        int   s;
        logic ci;
        alu_t r;
        s = (i == 0) ? 1 : 4;
        @(negedge clk);
        ba_v[i] = a; bb_v[i] = b; bop_v[i] = op; wuse_v[i] = usec;
        wreq_v[i] = 1'b1; wrdy_v[i] = 1'b0;
        chk("wack_idle", 32'(wack_v[i]), 32'd1);
`ifdef ALU_SEQ_CARRY_CHAIN_EN
        ci = usec & exp_flags[i][3];
`else
        ci = 1'b0;
`endif
        @(posedge clk);
        #1;
        ba_v[i] = 8'($urandom); bb_v[i] = 8'($urandom); bop_v[i] = 3'($urandom);
        wuse_v[i] = 1'($urandom); wreq_v[i] = 1'b0;
        for (int n = 1; n <= s; n++) begin
            @(negedge clk);
            chk("wvalid_settle", 32'(wvalid_v[i]), 32'd0);
            chk("wack_settle", 32'(wack_v[i]), 32'd0);
            if (n == 1) begin
                chk("bas_settle",  32'(bas_v[i]),  32'(a));
                chk("bbs_settle",  32'(bbs_v[i]),  32'(b));
                chk("bops_settle", 32'(bops_v[i]), 32'(op));
                chk("wci_settle",  32'(wci_v[i]),  32'(ci));
            end
        end
        if (op != 3'd7) begin
            r = alu_f(op, a, b, ci);
            exp_res[i]   = r.res;
            exp_flags[i] = {(op <= 3'd2) ? r.co : 1'b0, r.al, r.eq, r.z};
        end
        @(negedge clk);
        chk("wvalid_hold", 32'(wvalid_v[i]), 32'd1);
        chk("bres", 32'(bres_v[i]), 32'(exp_res[i]));
        chk("flags", 32'(flags_of(i)), 32'(exp_flags[i]));
        chk_idle_drive(i, "hold");
        wreq_v[i] = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("wvalid_stall", 32'(wvalid_v[i]), 32'd1);
            chk("wack_stall", 32'(wack_v[i]), 32'd0);
            chk("bres_stall", 32'(bres_v[i]), 32'(exp_res[i]));
            chk("flags_stall", 32'(flags_of(i)), 32'(exp_flags[i]));
        end
        wrdy_v[i] = 1'b1;
        wreq_v[i] = 1'b0;
        @(negedge clk);
        wrdy_v[i] = 1'b0;
        chk("wack_after", 32'(wack_v[i]), 32'd1);
        chk("wvalid_after", 32'(wvalid_v[i]), 32'd0);
        chk("bres_after", 32'(bres_v[i]), 32'(exp_res[i]));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 2; i++) begin
            wrst_v[i] = 1'b1; wreq_v[i] = 1'b0; bop_v[i] = 3'd7;
            ba_v[i] = 8'h00; bb_v[i] = 8'h00; wuse_v[i] = 1'b0; wrdy_v[i] = 1'b0;
            exp_res[i] = 8'h00; exp_flags[i] = 4'h0;
        end
        repeat (2) @(negedge clk);
        wrst_v[0] = 1'b0;
        wrst_v[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_wack", 32'(wack_v[i]), 32'd1);
            chk("rst_wvalid", 32'(wvalid_v[i]), 32'd0);
            chk("rst_bres", 32'(bres_v[i]), 32'd0);
            chk("rst_flags", 32'(flags_of(i)), 32'd0);
            chk_idle_drive(i, "rst");
        end

        // Directed cases on the single-cycle-settle instance.
        do_op(0, 3'd0, 8'h7F, 8'h01, 1'b0, 0);
        do_op(0, 3'd0, 8'hFF, 8'h01, 1'b0, 0);
        chk("carry_set", 32'(fc_v[0]), 32'd1);
        do_op(0, 3'd0, 8'h00, 8'h00, 1'b1, 0);
        do_op(0, 3'd6, 8'h05, 8'h05, 1'b0, 5);
        do_op(0, 3'd7, 8'hA5, 8'h3C, 1'b1, 2);
        do_op(0, 3'd2, 8'h81, 8'h00, 1'b0, 0);
        do_op(0, 3'd0, 8'h10, 8'h20, 1'b1, 1);

        // Randomized traffic on both instances.
        for (int k = 0; k < 40; k++) begin
            do_op(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  1'($urandom), int'($urandom_range(0, 3)));
        end
        do_op(1, 3'd0, 8'h7F, 8'h01, 1'b0, 0);
        for (int k = 0; k < 6; k++) begin
            do_op(1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  1'($urandom), int'($urandom_range(0, 2)));
        end
        do_op(1, 3'd5, 8'hC3, 8'h18, 1'b0, 0);

        // Reset pulse during the second settle cycle aborts the op.
        @(negedge clk);
        ba_v[1] = 8'h10; bb_v[1] = 8'h22; bop_v[1] = 3'd0; wreq_v[1] = 1'b1;
        @(posedge clk);
        #1;
        wreq_v[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_settle", 32'(wack_v[1]), 32'd0);
        #1;
        wrst_v[1] = 1'b1;
        #1;
        exp_res[1]   = 8'h00;
        exp_flags[1] = 4'h0;
        chk("abort_wack", 32'(wack_v[1]), 32'd1);
        chk("abort_wvalid", 32'(wvalid_v[1]), 32'd0);
        chk("abort_bres", 32'(bres_v[1]), 32'd0);
        chk("abort_flags", 32'(flags_of(1)), 32'd0);
        chk_idle_drive(1, "abort");
        #1;
        wrst_v[1] = 1'b0;
        @(negedge clk);
        chk("abort_wack_release", 32'(wack_v[1]), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(wvalid_v[1]), 32'd0);
            chk("abort_bres_hold", 32'(bres_v[1]), 32'd0);
        end
        do_op(1, 3'd0, 8'h01, 8'h02, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter SETTLE, default 1, range 1..15: ALU settle cycles between operand drive and result capture.
REQ-002 SHALL have port wclk  in  1  sole clock, rising edge.
REQ-003 SHALL have port wrst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports wreq in 1 (request valid) and wack out 1 (request accepted when wreq&wack at an edge).
REQ-005 SHALL have ports bop in 3 (0 ADD,1 SHR,2 SHL,3 NOT,4 AND,5 OR,6 XOR/CMP,7 NOP), ba in 8, bb in 8, wuse_c in 1 (carry-in from stored C).
REQ-006 SHALL have ALU-facing ports bas out 8, bbs out 8, wci out 1, bops out 3, and inputs bcs 8, wco 1, weqo 1, walo 1, wz 1.
REQ-007 SHALL have ports bres out 8, wflag_c/wflag_a/wflag_e/wflag_z out 1 each, wvalid out 1, wrdy in 1.

Function
REQ-008 SHALL implement FSM states IDLE, SETTLE, HOLD; wack=1 only in IDLE; wvalid=1 only in HOLD.
REQ-009 IDLE: on wreq, SHALL latch ba, bb, bop and carry-in, load counter with SETTLE-1, go SETTLE; upstream may change inputs after the accepting edge.
REQ-010 SETTLE: SHALL drive bas/bbs/bops/wci from latches; counter decrements each edge; at counter 0 SHALL capture result and go HOLD.
REQ-011 Latency: accept at edge t SHALL give wvalid high after edge t+SETTLE; minimum op period SETTLE+2 cycles with wrdy held high.
REQ-012 HOLD: bres and flags SHALL stay stable; wrdy=1 at an edge returns to IDLE; wrdy=0 holds indefinitely.
REQ-013 IDLE and HOLD SHALL drive bas=bbs=0, wci=0, bops=7 (no ALU enable).
REQ-014 Capture for ops 0-6: bres<=bcs, wflag_z<=wz, wflag_e<=weqo, wflag_a<=walo.
REQ-015 wflag_c SHALL capture wco for ops 0,1,2 and clear to 0 for ops 3-6.
REQ-016 Op 7 (NOP) SHALL complete the full handshake with bres and all flags unchanged.
REQ-017 Carry-in SHALL be sampled at the accepting edge from wflag_c, so an op may chain on the previous op's carry.
REQ-018 wreq while not IDLE SHALL be ignored; requester holds wreq until accepted.

Reset
REQ-019 wrst SHALL force IDLE, bres=0x00, all flags 0, wvalid=0, latches 0, counter 0, asynchronously.
REQ-020 wrst in SETTLE or HOLD SHALL abort the op: no wvalid, no result/flag update after release.
REQ-021 After wrst deasserts, wack SHALL be 1 in the first cycle.

Configuration
REQ-022 With ALU_SEQ_CARRY_CHAIN_EN defined, latched carry-in SHALL be wuse_c & wflag_c.
REQ-023 Without ALU_SEQ_CARRY_CHAIN_EN, carry-in SHALL be 0; wuse_c stays a port and is ignored.

Structure
REQ-024 Package alu_seq_pkg SHALL hold op encodings (3-bit), flag index constants (C,A,E,Z) and FSM state encoding.
REQ-025 Flag register SHALL be sub-module alu_seq_flags (4 flags, capture enable, C-clear select, async reset).

Verification (bench pairs block with behavioural ALU model on the ALU-facing ports)
REQ-026 ADD ba=0x7F bb=0x01, SETTLE=1 -> wvalid one cycle after accept, bres=0x80, C=0, Z=0.
REQ-027 ADD 0xFF+0x01 then (macro on) ADD 0x00+0x00 wuse_c=1 -> first bres=0x00 C=1 Z=1; second wci=1, bres=0x01, C=0.
REQ-028 XOR ba=0x05 bb=0x05 -> bres=0x00, E=1, Z=1, C=0; then NOP -> bres and flags unchanged.
REQ-029 wrdy low 5 cycles in HOLD with wreq high -> bres/flags/wvalid stable, wack=0, no second accept until wrdy.
REQ-030 SETTLE=4, wrst pulsed in 2nd SETTLE cycle -> all outputs reset, wack=1 after release, no wvalid.
